// File: rtl/down_counter_preval.sv
// Purpose: 4-digit BCD MM:SS countdown timer; loads clamped presets, steps down once per TICK_DIV ticks, stops at 00:00.
// Latency: digits/running/done are registered; a qualifying tick shows its new digits the cycle after its edge.
// Backpressure: none; load/s/tick are single-cycle pulses honoured with priority r > load > s > tick.
//
// Ports:
//   clk                  system clock, rising edge
//   r                    synchronous active-high reset
//   tick                 prescaler enable pulse from the clock divider
//   load                 capture preval_0..3 (clamped to legal BCD) and go IDLE
//   s                    start/pause toggle
//   preval_0..preval_3   preset digits, preval_0 = seconds ones
//   d0..d3               current digits, d0 = seconds ones
//   running              high while counting
//   done                 high in DONE
//
// Optional feature macro AUTO_RELOAD_EN: when defined, reaching 00:00 while running
// reloads the last loaded preset, keeps running and pulses done for one cycle.
// When undefined, the timer parks in DONE with done held until load or r.
module down_counter_preval #(
    parameter int TICK_DIV     = 10,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       r,
    input  logic       tick,
    input  logic       load,
    input  logic       s,
    input  logic [3:0] preval_0,
    input  logic [3:0] preval_1,
    input  logic [3:0] preval_2,
    input  logic [3:0] preval_3,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       running,
    output logic       done
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    D1_MAX  = 4'(SEC_TENS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] pre;

    logic [3:0] c0, c1, c2, c3;
    logic [3:0] n0, n1, n2, n3;
    logic       cur_zero;
    logic       next_zero;

`ifdef AUTO_RELOAD_EN
    logic [3:0] p0, p1, p2, p3;
`endif

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

    assign c0 = clamp(preval_0, 4'd9);
    assign c1 = clamp(preval_1, D1_MAX);
    assign c2 = clamp(preval_2, 4'd9);
    assign c3 = clamp(preval_3, 4'd9);

    assign cur_zero = (d0 == 4'd0) && (d1 == 4'd0) && (d2 == 4'd0) && (d3 == 4'd0);

    // Borrow chain d0 -> d1 -> d2 -> d3. Only evaluated while counting, and the
    // timer leaves RUN (or reloads) on reaching 00:00, so d3 never underflows.
    always_comb begin
        n0 = d0;
        n1 = d1;
        n2 = d2;
        n3 = d3;
        if (d0 != 4'd0) begin
            n0 = d0 - 4'd1;
        end else begin
            n0 = 4'd9;
            if (d1 != 4'd0) begin
                n1 = d1 - 4'd1;
            end else begin
                n1 = D1_MAX;
                if (d2 != 4'd0) begin
                    n2 = d2 - 4'd1;
                end else begin
                    n2 = 4'd9;
                    n3 = d3 - 4'd1;
                end
            end
        end
    end

    assign next_zero = (n0 == 4'd0) && (n1 == 4'd0) && (n2 == 4'd0) && (n3 == 4'd0);

    always_ff @(posedge clk) begin
        if (r) begin
            d0      <= 4'd0;
            d1      <= 4'd0;
            d2      <= 4'd0;
            d3      <= 4'd0;
            pre     <= '0;
            state   <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            p0      <= 4'd0;
            p1      <= 4'd0;
            p2      <= 4'd0;
            p3      <= 4'd0;
`endif
        end else begin
`ifdef AUTO_RELOAD_EN
            // done is a one-cycle pulse on reload; only DONE holds it as a level.
            if (state != ST_DONE) begin
                done <= 1'b0;
            end
`endif
            if (load) begin
                d0      <= c0;
                d1      <= c1;
                d2      <= c2;
                d3      <= c3;
                pre     <= '0;
                state   <= ST_IDLE;
                running <= 1'b0;
                done    <= 1'b0;
`ifdef AUTO_RELOAD_EN
                p0      <= c0;
                p1      <= c1;
                p2      <= c2;
                p3      <= c3;
`endif
            end else if (s) begin
                case (state)
                    ST_IDLE, ST_PAUSE: begin
                        if (cur_zero) begin
                            state   <= ST_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Prescaler is left alone so partial progress survives the pause.
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end else if (tick && (state == ST_RUN)) begin
                if (pre == PS_LAST) begin
                    pre <= '0;
                    if (next_zero) begin
`ifdef AUTO_RELOAD_EN
                        d0   <= p0;
                        d1   <= p1;
                        d2   <= p2;
                        d3   <= p3;
                        done <= 1'b1;
`else
                        d0      <= 4'd0;
                        d1      <= 4'd0;
                        d2      <= 4'd0;
                        d3      <= 4'd0;
                        state   <= ST_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
`endif
                    end else begin
                        d0 <= n0;
                        d1 <= n1;
                        d2 <= n2;
                        d3 <= n3;
                    end
                end else begin
                    pre <= pre + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_down_counter_preval.sv
// Purpose: self-checking bench for down_counter_preval with three parameterisations sharing one stimulus.
// Latency: checks registered outputs every negedge against a count-based model, plus literal spot checks.
// Backpressure: none; stimulus is a fixed directed sequence with bounded cycle counts.
module tb_down_counter_preval;

    logic       clk;
    logic       r, tick, load, s;
    logic [3:0] pv0, pv1, pv2, pv3;

    // instance 0: TICK_DIV=1,  SEC_TENS_MAX=5
    // instance 1: TICK_DIV=10, SEC_TENS_MAX=5
    // instance 2: TICK_DIV=1,  SEC_TENS_MAX=9
    logic [15:0] dig_o [3];
    logic        run_o [3];
    logic        done_o[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int TD = (g == 1) ? 10 : 1;
        localparam int SM = (g == 2) ? 9 : 5;
        logic [3:0] q0, q1, q2, q3;
        logic       qr, qd;
        down_counter_preval #(
            .TICK_DIV    (TD),
            .SEC_TENS_MAX(SM)
        ) dut (
            .clk     (clk),
            .r       (r),
            .tick    (tick),
            .load    (load),
            .s       (s),
            .preval_0(pv0),
            .preval_1(pv1),
            .preval_2(pv2),
            .preval_3(pv3),
            .d0      (q0),
            .d1      (q1),
            .d2      (q2),
            .d3      (q3),
            .running (qr),
            .done    (qd)
        );
        assign dig_o[g]  = {q3, q2, q1, q0};
        assign run_o[g]  = qr;
        assign done_o[g] = qd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: the timer value as a single mixed-radix count ----------------
    function automatic int td_of(input int i);
        return (i == 1) ? 10 : 1;
    endfunction

    function automatic int sm_of(input int i);
        return (i == 2) ? 9 : 5;
    endfunction

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int to_cnt(input int a0, input int a1, input int a2, input int a3, input int smx);
        int rad;
        rad = smx + 1;
        return lim(a0, 9) + 10 * lim(a1, smx) + 10 * rad * lim(a2, 9) + 100 * rad * lim(a3, 9);
    endfunction

    function automatic logic [15:0] to_dig(input int c, input int smx);
        int t, e0, e1, e2, e3;
        e0 = c % 10;
        t  = c / 10;
        e1 = t % (smx + 1);
        t  = t / (smx + 1);
        e2 = t % 10;
        e3 = t / 10;
        return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    endfunction

    // states: 0 idle, 1 run, 2 pause, 3 done
    int m_cnt[3], m_pre[3], m_st[3], m_preset[3];
    bit m_pulse[3];
    bit chk_en = 1'b0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_st[i] = 0; m_preset[i] = 0; m_pulse[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                m_pulse[i] = 1'b0;
                if (r) begin
                    m_cnt[i] = 0; m_pre[i] = 0; m_st[i] = 0; m_preset[i] = 0;
                end else if (load) begin
                    m_cnt[i]    = to_cnt(pv0, pv1, pv2, pv3, sm_of(i));
                    m_preset[i] = m_cnt[i];
                    m_pre[i]    = 0;
                    m_st[i]     = 0;
                end else if (s) begin
                    if (m_st[i] == 0 || m_st[i] == 2)
                        m_st[i] = (m_cnt[i] == 0) ? 3 : 1;
                    else if (m_st[i] == 1)
                        m_st[i] = 2;
                end else if (tick && m_st[i] == 1) begin
                    m_pre[i]++;
                    if (m_pre[i] == td_of(i)) begin
                        m_pre[i] = 0;
                        m_cnt[i]--;
                        if (m_cnt[i] == 0) begin
`ifdef AUTO_RELOAD_EN
                            m_cnt[i]   = m_preset[i];
                            m_pulse[i] = 1'b1;
`else
                            m_st[i] = 3;
`endif
                        end
                    end
                end
            end
            if (r) chk_en = 1'b1;
        end
    end

    // Compare every cycle once reset has been applied.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("inst%0d digits", i), int'(dig_o[i]), int'(to_dig(m_cnt[i], sm_of(i))));
                    check($sformatf("inst%0d running", i), int'(run_o[i]), int'(m_st[i] == 1));
                    check($sformatf("inst%0d done", i), int'(done_o[i]), int'(m_st[i] == 3 || m_pulse[i]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int a3, input int a2, input int a1, input int a0);
        pv3 = 4'(a3); pv2 = 4'(a2); pv1 = 4'(a1); pv0 = 4'(a0);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_s();
        s = 1'b1;
        cyc();
        s = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        r = 1'b1; tick = 1'b0; load = 1'b0; s = 1'b0;
        pv0 = 4'd0; pv1 = 4'd0; pv2 = 4'd0; pv3 = 4'd0;
        cyc();
        check("reset digits", int'(dig_o[0]), 'h0000);
        check("reset running", int'(run_o[0]), 0);
        check("reset done", int'(done_o[0]), 0);
        r = 1'b0;
        cyc();

        // 01:05 counted down one step per tick
        do_load(0, 1, 0, 5);
        do_s();
        ticks(5);
        check("0105 after 5", int'(dig_o[0]), 'h0100);
        ticks(1);
        check("0105 borrow to 0059", int'(dig_o[0]), 'h0059);
        ticks(59);
        check("0105 end digits", int'(dig_o[0]), 'h0000);
        check("0105 end done", int'(done_o[0]), 1);
        check("0105 end running", int'(run_o[0]), 0);
        check("decimal 105-65", int'(dig_o[2]), 'h0040);
        ticks(3);
        check("no wrap below zero", int'(dig_o[0]), 'h0000);

        // 10:00 -> 09:59, then preset zero goes straight to DONE
        do_load(1, 0, 0, 0);
        do_s();
        ticks(1);
        check("1000 to 0959", int'(dig_o[0]), 'h0959);
        check("decimal 1000 to 0999", int'(dig_o[2]), 'h0999);
        do_load(0, 0, 0, 0);
        do_s();
        check("zero preset done", int'(done_o[0]), 1);
        check("zero preset running", int'(run_o[0]), 0);

        // clamping
        do_load(4'hC, 4'hA, 4'h7, 4'hF);
        check("clamp tens max 5", int'(dig_o[0]), 'h9959);
        check("clamp tens max 9", int'(dig_o[2]), 'h9979);
        check("clamp clears done", int'(done_o[0]), 0);

        // prescaler holds across pause
        do_load(0, 0, 1, 0);
        do_s();
        ticks(4);
        do_s();
        ticks(20);
        do_s();
        ticks(5);
        check("div10 before 6th", int'(dig_o[1]), 'h0010);
        ticks(1);
        check("div10 on 6th", int'(dig_o[1]), 'h0009);
        check("div1 reached zero", int'(done_o[0]), 1);

        // s coincident with the final tick: pause wins
        do_load(0, 0, 0, 1);
        do_s();
        s = 1'b1; tick = 1'b1;
        cyc();
        s = 1'b0; tick = 1'b0;
        check("s+tick digits", int'(dig_o[0]), 'h0001);
        check("s+tick running", int'(run_o[0]), 0);
        check("s+tick done", int'(done_o[0]), 0);

        // load coincident with s, then with tick
        s = 1'b1;
        do_load(0, 0, 0, 3);
        s = 1'b0;
        check("load+s running", int'(run_o[0]), 0);
        check("load+s digits", int'(dig_o[0]), 'h0003);
        do_s();
        tick = 1'b1;
        do_load(0, 0, 0, 7);
        tick = 1'b0;
        check("load+tick digits", int'(dig_o[0]), 'h0007);
        check("load+tick running", int'(run_o[0]), 0);

        // end of count: reload or park
        do_load(0, 0, 0, 2);
        do_s();
        ticks(1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
`ifdef AUTO_RELOAD_EN
        check("reload digits", int'(dig_o[0]), 'h0002);
        check("reload done pulse", int'(done_o[0]), 1);
        check("reload running", int'(run_o[0]), 1);
        cyc();
        check("reload done cleared", int'(done_o[0]), 0);
`else
        check("park digits", int'(dig_o[0]), 'h0000);
        check("park done", int'(done_o[0]), 1);
        check("park running", int'(run_o[0]), 0);
        cyc();
        check("park done held", int'(done_o[0]), 1);
`endif

        // random activity, then reset dominating every other input
        for (int k = 0; k < 80; k++) begin
            load = ($urandom_range(0, 15) == 0);
            s    = ($urandom_range(0, 5) == 0);
            tick = 1'($urandom_range(0, 1));
            pv0  = 4'($urandom_range(0, 15));
            pv1  = 4'($urandom_range(0, 15));
            pv2  = 4'($urandom_range(0, 15));
            pv3  = 4'($urandom_range(0, 15));
            cyc();
        end
        r = 1'b1; load = 1'b1; s = 1'b1; tick = 1'b1;
        cyc();
        r = 1'b0; load = 1'b0; s = 1'b0; tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d digits", i), int'(dig_o[i]), 'h0000);
            check($sformatf("rst%0d running", i), int'(run_o[i]), 0);
            check($sformatf("rst%0d done", i), int'(done_o[i]), 0);
        end
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
